// File: rtl/store_fwd_ctrl_pkg.sv
// Shared types and constants for the store-data forwarding controller.
// The package fixes the register-address width for the stage-info struct.
package store_fwd_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] WD_SEL_REG2  = 2'b00;
    localparam logic [1:0] WD_SEL_MEMRD = 2'b01;
    localparam logic [1:0] WD_SEL_WB    = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              regwrite;
        logic              memread;
        logic              is_store;
        logic [REG_AW-1:0] rt;
    } stage_info_t;

    // True when slot s will write register r, which must not be the hardwired zero register.
    function automatic logic produces(stage_info_t s, logic [REG_AW-1:0] r,
                                      logic [REG_AW-1:0] zeroReg);
        return s.valid & s.regwrite & (s.dst == r) & (r != zeroReg);
    endfunction

endpackage

// File: rtl/store_fwd_ctrl_fwd_stage_reg.sv
// One shadow pipeline slot: loads new stage info each cycle, or becomes a bubble.
// A bubble clears the whole slot so stale fields never look like a producer.
module fwd_stage_reg
    import store_fwd_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble_i,
    input  stage_info_t d_i,
    output stage_info_t q_o
);

    stage_info_t slot_q;

    always_ff @(posedge clk) begin
        if (rst || bubble_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= d_i;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/store_fwd_ctrl.sv
// Load-use hazard detection and store-data mux select for the EX stage.
// Tracks EX/MEM/WB destination info in a shadow pipeline beside the ID/EX register.
module store_fwd_ctrl
    import store_fwd_ctrl_pkg::stage_info_t;
    import store_fwd_ctrl_pkg::produces;
    import store_fwd_ctrl_pkg::WD_SEL_REG2;
    import store_fwd_ctrl_pkg::WD_SEL_MEMRD;
    import store_fwd_ctrl_pkg::WD_SEL_WB;
#(
    parameter int          REG_AW   = store_fwd_ctrl_pkg::REG_AW,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_store,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        writedata_sel,
    output logic              ex_store
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

    stage_info_t ex_q;
    stage_info_t mem_q;
    stage_info_t wb_q;
    stage_info_t exIn_d;
    logic        exBubble;
    logic        hazardRs;
    logic        hazardRt;
    logic [1:0]  wdSel_d;
    logic [1:0]  wdSel_q;

    // Store data sourced from a load never stalls: only ALU operands are hazard-checked.
    always_comb begin
        hazardRs = id_use_rs & (id_rs == ex_q.dst);
        hazardRt = id_use_rt & (id_rt == ex_q.dst);
        stall    = ~rst & id_valid & ~flush & ex_q.valid & ex_q.memread &
                   (ex_q.dst != ZERO_ADDR) & (hazardRs | hazardRt);
        exBubble = flush | stall;
    end

    always_comb begin
        exIn_d          = '0;
        exIn_d.valid    = id_valid;
        exIn_d.dst      = id_dst;
        exIn_d.regwrite = id_regwrite;
        exIn_d.memread  = id_memread;
        exIn_d.is_store = id_is_store;
        exIn_d.rt       = id_rt;
    end

    // Current EX/MEM become MEM/WB when the store reaches EX; the younger EX producer wins.
    always_comb begin
        wdSel_d = WD_SEL_REG2;
        if (id_valid && !exBubble && id_is_store && (id_rt != ZERO_ADDR)) begin
            if (produces(ex_q, id_rt, ZERO_ADDR)) begin
                wdSel_d = ex_q.memread ? WD_SEL_MEMRD : WD_SEL_REG2;
            end else if (produces(mem_q, id_rt, ZERO_ADDR)) begin
                wdSel_d = WD_SEL_WB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdSel_q <= WD_SEL_REG2;
        end else begin
            wdSel_q <= wdSel_d;
        end
    end

    fwd_stage_reg u_ex (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (exBubble),
        .d_i      (exIn_d),
        .q_o      (ex_q)
    );

    fwd_stage_reg u_mem (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .d_i      (ex_q),
        .q_o      (mem_q)
    );

    fwd_stage_reg u_wb (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .d_i      (mem_q),
        .q_o      (wb_q)
    );

    assign writedata_sel = wdSel_q;
    assign ex_store      = ex_q.valid & ex_q.is_store;

endmodule

// File: tb/tb_store_fwd_ctrl.sv
// Self-checking bench for store_fwd_ctrl: hand-derived expectations per instruction,
// queued when the instruction is driven and compared when it sits in EX.
module tb_store_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_is_store;
    logic [4:0] id_dst;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic       stall;
    logic [1:0] writedata_sel;
    logic       ex_store;

    int         checks   = 0;
    int         failures = 0;
    logic [2:0] expQ[$];
    string      lastTag  = "none";

    always #5 clk = ~clk;

    store_fwd_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_is_store   (id_is_store),
        .id_dst        (id_dst),
        .id_regwrite   (id_regwrite),
        .id_memread    (id_memread),
        .flush         (flush),
        .stall         (stall),
        .writedata_sel (writedata_sel),
        .ex_store      (ex_store)
    );

    task automatic checkOutput(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Compare the EX-stage outputs against the entry queued when that slot was captured.
    task automatic popAndCheck();
        logic [2:0] e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({lastTag, "/sel"}, writedata_sel, e[1:0]);
            checkOutput({lastTag, "/ex_store"}, {1'b0, ex_store}, {1'b0, e[2]});
        end
    endtask

    // A stalling instruction is held for one extra cycle; the repeat must not stall.
    task automatic applyStimulus(input string tag, input logic v, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urs, input logic urt,
                                 input logic st, input logic [4:0] dst, input logic rw,
                                 input logic mr, input logic fl, input logic expStall,
                                 input logic [1:0] expSel);
        int   n;
        logic es;
        n = expStall ? 2 : 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            popAndCheck();
            rst         = 1'b0;
            id_valid    = v;
            id_rs       = rs;
            id_rt       = rt;
            id_use_rs   = urs;
            id_use_rt   = urt;
            id_is_store = st;
            id_dst      = dst;
            id_regwrite = rw;
            id_memread  = mr;
            flush       = fl;
            es          = (i == 0) ? expStall : 1'b0;
            #1;
            checkOutput({tag, "/stall"}, {1'b0, stall}, {1'b0, es});
            if (fl || es || !v) expQ.push_back(3'b000);
            else                expQ.push_back({st, expSel});
            lastTag = (i == 0 && es) ? {tag, "_bubble"} : tag;
        end
    endtask

    // Reset asserted while a load-use hazard is presented in ID.
    task automatic resetCycle(input string tag, input logic [4:0] rs);
        @(negedge clk);
        popAndCheck();
        rst         = 1'b1;
        id_valid    = 1'b1;
        id_rs       = rs;
        id_rt       = 5'd1;
        id_use_rs   = 1'b1;
        id_use_rt   = 1'b1;
        id_is_store = 1'b0;
        id_dst      = 5'd17;
        id_regwrite = 1'b1;
        id_memread  = 1'b0;
        flush       = 1'b0;
        #1;
        checkOutput({tag, "/stall"}, {1'b0, stall}, 2'b00);
        expQ.push_back(3'b000);
        lastTag = tag;
    endtask

    task automatic lw(input string tag, input logic [4:0] dst);
        applyStimulus(tag, 1'b1, 5'd1, dst, 1'b1, 1'b0, 1'b0, dst, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic add(input string tag, input logic [4:0] dst, input logic [4:0] rs,
                       input logic [4:0] rt, input logic expStall);
        applyStimulus(tag, 1'b1, rs, rt, 1'b1, 1'b1, 1'b0, dst, 1'b1, 1'b0, 1'b0, expStall, 2'b00);
    endtask

    task automatic sw(input string tag, input logic [4:0] rt, input logic [4:0] base,
                      input logic expStall, input logic [1:0] expSel);
        applyStimulus(tag, 1'b1, base, rt, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, expStall, expSel);
    endtask

    task automatic nop();
        applyStimulus("nop", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        rst         = 1'b1;
        id_valid    = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_use_rs   = 1'b0;
        id_use_rt   = 1'b0;
        id_is_store = 1'b0;
        id_dst      = '0;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        flush       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset/sel", writedata_sel, 2'b00);
        checkOutput("reset/ex_store", {1'b0, ex_store}, 2'b00);
        checkOutput("reset/stall", {1'b0, stall}, 2'b00);

        lw("lw5", 5'd5);
        sw("sw5_memrd", 5'd5, 5'd1, 1'b0, 2'b01);
        nop(); nop();

        add("add6", 5'd6, 5'd2, 5'd3, 1'b0);
        nop();
        sw("sw6_wb", 5'd6, 5'd1, 1'b0, 2'b10);
        nop(); nop();

        add("add6b", 5'd6, 5'd2, 5'd3, 1'b0);
        sw("sw6_alu", 5'd6, 5'd1, 1'b0, 2'b00);
        nop(); nop();

        lw("lw7", 5'd7);
        add("add8_rs_hazard", 5'd8, 5'd7, 5'd1, 1'b1);
        nop(); nop();

        lw("lw10", 5'd10);
        add("add11_rt_hazard", 5'd11, 5'd1, 5'd10, 1'b1);
        nop(); nop();

        lw("lw12", 5'd12);
        sw("sw4_base_hazard", 5'd4, 5'd12, 1'b1, 2'b00);
        nop(); nop();

        lw("lw9", 5'd9);
        add("add9", 5'd9, 5'd2, 5'd3, 1'b0);
        sw("sw9_youngest", 5'd9, 5'd1, 1'b0, 2'b00);
        nop(); nop();

        lw("lw9b", 5'd9);
        nop();
        sw("sw9_wb", 5'd9, 5'd1, 1'b0, 2'b10);
        nop(); nop();

        lw("lw20a", 5'd20);
        lw("lw20b", 5'd20);
        sw("sw20_youngest_load", 5'd20, 5'd1, 1'b0, 2'b01);
        nop(); nop();

        lw("lw0", 5'd0);
        sw("sw0", 5'd0, 5'd1, 1'b0, 2'b00);
        lw("lw0b", 5'd0);
        add("add13_zero", 5'd13, 5'd0, 5'd0, 1'b0);
        nop(); nop();

        lw("lw14", 5'd14);
        applyStimulus("add15_flush", 1'b1, 5'd14, 5'd1, 1'b1, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0,
                      1'b1, 1'b0, 2'b00);
        sw("sw14_after_flush", 5'd14, 5'd1, 1'b0, 2'b10);
        nop(); nop();

        lw("lw18", 5'd18);
        applyStimulus("invalid_hazard", 1'b0, 5'd18, 5'd18, 1'b1, 1'b1, 1'b0, 5'd19, 1'b1, 1'b0,
                      1'b0, 1'b0, 2'b00);
        nop(); nop();

        lw("lw16", 5'd16);
        resetCycle("rst_hazard", 5'd16);
        sw("sw16_after_rst", 5'd16, 5'd1, 1'b0, 2'b00);
        nop();

        @(negedge clk);
        popAndCheck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
